// File: rtl/mem_line_responder.sv
// Memory-side line responder: accepts one 128-bit line read or write at a time
// and completes it with a single-cycle mem_ready pulse LATENCY cycles later.
module mem_line_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 8,
    parameter int LINE_W  = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [27:0]       mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              proto_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                opWr_q, opWr_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                protoErr_q, protoErr_d;
    logic [LINE_W-1:0]   rdata_q;
    logic [LINE_W-1:0]   lines_q [DEPTH];
    logic                complete;

    // Tag bits above the index are deliberately dropped so higher addresses alias.
    generate
        if (ADDR_W < 28) begin : g_alias
            logic unusedAddrBits;
            assign unusedAddrBits = ^mem_addr[27:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opWr_q     <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
            protoErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opWr_q     <= opWr_d;
            index_q    <= index_d;
            wdata_q    <= wdata_d;
            protoErr_q <= protoErr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opWr_d     = opWr_q;
        index_d    = index_q;
        wdata_d    = wdata_q;
        protoErr_d = protoErr_q;
        case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    opWr_d  = mem_write;
                    index_d = mem_addr[ADDR_W-1:0];
                    if (mem_write) begin
                        wdata_d = mem_wdata;
                    end
                    if (mem_write && mem_read) begin
                        protoErr_d = 1'b1;
                    end
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The _d values are used so a LATENCY of 1 completes straight from IDLE.
    assign complete = (state_d == DONE);

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                lines_q[i] <= '0;
            end
        end else if (complete && opWr_d) begin
            lines_q[index_d] <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            rdata_q <= '0;
        end else if (complete && !opWr_d) begin
            rdata_q <= lines_q[index_d];
        end
    end

    assign mem_ready = (state_q == DONE);
    assign mem_rdata = rdata_q;
    assign proto_err = protoErr_q;

endmodule
